rename_seq_alloc: RTL and testbench

//  Parametrised sequence-number allocator for the rename stage. Assigns up to WIDTH uops per cycle:
//  - a ROB SqN, a load SqN, a store SqN and an ordering bit.

---
 rtl/rename_pkg.sv | 19 +
 rtl/rename_seq_alloc_if.sv | 44 ++++
 rtl/seq_prefix_alloc.sv | 64 ++++++
 rtl/rename_seq_alloc.sv | 121 ++++++++++++
 tb/tb_rename_seq_alloc.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared definitions for the rename-stage sequence allocator:
// FU type codes carried on the decode bus and the default SqN type.
package rename_pkg;

    localparam int SQN_W_DEF = 7;

    typedef logic [SQN_W_DEF-1:0] SqN_t;

    localparam logic [3:0] FU_INT = 4'd0;
    localparam logic [3:0] FU_LD  = 4'd1;
    localparam logic [3:0] FU_ST  = 4'd2;
    localparam logic [3:0] FU_BR  = 4'd3;
    localparam logic [3:0] FU_MUL = 4'd4;
    localparam logic [3:0] FU_DIV = 4'd5;
    localparam logic [3:0] FU_FPU = 4'd6;
    localparam logic [3:0] FU_CSR = 4'd7;
    localparam logic [3:0] FU_RN  = 4'd8;

endpackage

// File: rtl/rename_seq_alloc_if.sv
// Decode-side bundle for the sequence allocator: uop group in, commit and
// recovery pointers in, allocated sequence numbers and stall out.
interface rename_seq_alloc_if #(
    parameter int WIDTH = 4,
    parameter int SQN_W = 7
);
    logic [WIDTH-1:0]       IN_uopValid;
    logic [WIDTH*4-1:0]     IN_uopFu;
    logic                   IN_ready;
    logic                   IN_branchTaken;
    logic [SQN_W-1:0]       IN_branchSqN;
    logic [SQN_W-1:0]       IN_branchLoadSqN;
    logic [SQN_W-1:0]       IN_branchStoreSqN;
    logic [SQN_W-1:0]       IN_comSqN;
    logic [SQN_W-1:0]       IN_comLoadSqN;
    logic [SQN_W-1:0]       IN_comStoreSqN;
    logic                   OUT_stall;
    logic [WIDTH-1:0]       OUT_uopValid;
    logic [WIDTH*SQN_W-1:0] OUT_uopSqN;
    logic [WIDTH*SQN_W-1:0] OUT_uopLoadSqN;
    logic [WIDTH*SQN_W-1:0] OUT_uopStoreSqN;
    logic [WIDTH-1:0]       OUT_uopOrdering;
    logic [SQN_W-1:0]       OUT_nextSqN;
    logic [SQN_W-1:0]       OUT_nextLoadSqN;
    logic [SQN_W-1:0]       OUT_nextStoreSqN;

    modport master (
        output IN_uopValid, IN_uopFu, IN_ready, IN_branchTaken,
               IN_branchSqN, IN_branchLoadSqN, IN_branchStoreSqN,
               IN_comSqN, IN_comLoadSqN, IN_comStoreSqN,
        input  OUT_stall, OUT_uopValid, OUT_uopSqN, OUT_uopLoadSqN,
               OUT_uopStoreSqN, OUT_uopOrdering, OUT_nextSqN,
               OUT_nextLoadSqN, OUT_nextStoreSqN
    );

    modport slave (
        input  IN_uopValid, IN_uopFu, IN_ready, IN_branchTaken,
               IN_branchSqN, IN_branchLoadSqN, IN_branchStoreSqN,
               IN_comSqN, IN_comLoadSqN, IN_comStoreSqN,
        output OUT_stall, OUT_uopValid, OUT_uopSqN, OUT_uopLoadSqN,
               OUT_uopStoreSqN, OUT_uopOrdering, OUT_nextSqN,
               OUT_nextLoadSqN, OUT_nextStoreSqN
    );
endinterface

// File: rtl/seq_prefix_alloc.sv
// Combinational lane walk: exclusive prefix counts of valid lanes, loads and
// stores, the ordering bit each lane samples, and the group totals.
module seq_prefix_alloc
    import rename_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       valid,
    input  logic [WIDTH*4-1:0]     fu,
    input  logic                   ord_in,
    output logic [WIDTH*CNT_W-1:0] pre_valid,
    output logic [WIDTH*CNT_W-1:0] pre_ld,
    output logic [WIDTH*CNT_W-1:0] pre_st,
    output logic [WIDTH-1:0]       lane_ord,
    output logic [WIDTH-1:0]       lane_is_st,
    output logic [CNT_W-1:0]       n,
    output logic [CNT_W-1:0]       nl,
    output logic [CNT_W-1:0]       ns,
    output logic                   ord_out
);
    logic [CNT_W-1:0] run_v;
    logic [CNT_W-1:0] run_l;
    logic [CNT_W-1:0] run_s;
    logic             run_o;
    logic [3:0]       lane_fu;

    // Walk lanes in order; invalid lanes see the running values but change nothing.
    always_comb begin
        run_v      = '0;
        run_l      = '0;
        run_s      = '0;
        run_o      = ord_in;
        lane_fu    = '0;
        pre_valid  = '0;
        pre_ld     = '0;
        pre_st     = '0;
        lane_ord   = '0;
        lane_is_st = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_fu                    = fu[4*i +: 4];
            pre_valid[CNT_W*i +: CNT_W] = run_v;
            pre_ld[CNT_W*i +: CNT_W]    = run_l;
            pre_st[CNT_W*i +: CNT_W]    = run_s;
            lane_ord[i]                = run_o;
            lane_is_st[i]              = valid[i] && (lane_fu == FU_ST);
            if (valid[i]) begin
                run_v = run_v + CNT_W'(1);
                if (lane_fu == FU_LD) run_l = run_l + CNT_W'(1);
                if (lane_fu == FU_ST) run_s = run_s + CNT_W'(1);
                case (lane_fu)
                    FU_INT:                 run_o = ~run_o;
                    FU_DIV, FU_MUL:         run_o = 1'b1;
                    FU_FPU, FU_CSR, FU_BR:  run_o = 1'b0;
                    default:                run_o = run_o;
                endcase
            end
        end
        n       = run_v;
        nl      = run_l;
        ns      = run_s;
        ord_out = run_o;
    end
endmodule

// File: rtl/rename_seq_alloc.sv
// Rename-stage sequence allocator: hands out ROB/load/store SqNs and the
// ordering bit for a whole decode group at once, gated by ROB/LQ/SQ capacity
// against the commit pointers and by downstream backpressure.
module rename_seq_alloc
    import rename_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SQN_W    = 7,
    parameter int ROB_SIZE = 64,
    parameter int LQ_SIZE  = 16,
    parameter int SQ_SIZE  = 16
) (
    input  logic           clk,
    input  logic           rst,
    rename_seq_alloc_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [SQN_W-1:0]       sqn_cnt, ld_cnt, st_cnt;
    logic                   ord_bit;
    logic [WIDTH-1:0]       out_valid, out_ord;
    logic [WIDTH*SQN_W-1:0] out_sqn, out_ld, out_st;

    logic [WIDTH*CNT_W-1:0] pre_valid, pre_ld, pre_st;
    logic [WIDTH-1:0]       lane_ord, lane_is_st;
    logic [CNT_W-1:0]       n, nl, ns;
    logic                   ord_out;
    logic [WIDTH*SQN_W-1:0] lane_sqn, lane_ld, lane_st;

    logic [SQN_W-1:0]       rob_diff, lq_diff, sq_diff;
    logic [SQN_W:0]         rob_use, lq_use, sq_use;
    logic                   fit, hold, stall, accept;

    seq_prefix_alloc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_prefix (
        .valid      (bus.IN_uopValid),
        .fu         (bus.IN_uopFu),
        .ord_in     (ord_bit),
        .pre_valid  (pre_valid),
        .pre_ld     (pre_ld),
        .pre_st     (pre_st),
        .lane_ord   (lane_ord),
        .lane_is_st (lane_is_st),
        .n          (n),
        .nl         (nl),
        .ns         (ns),
        .ord_out    (ord_out)
    );

    // Per-lane SqNs from the counters plus prefix offsets; a store's own index includes itself.
    always_comb begin
        lane_sqn = '0;
        lane_ld  = '0;
        lane_st  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.IN_uopValid[i]) begin
                lane_sqn[SQN_W*i +: SQN_W] = sqn_cnt + SQN_W'(pre_valid[CNT_W*i +: CNT_W]);
                lane_ld[SQN_W*i +: SQN_W]  = ld_cnt + SQN_W'(pre_ld[CNT_W*i +: CNT_W]);
                lane_st[SQN_W*i +: SQN_W]  = st_cnt + SQN_W'(pre_st[CNT_W*i +: CNT_W])
                                           + SQN_W'(lane_is_st[i]);
            end
        end
    end

    // Occupancy is a modular distance, so wrap-around needs no special handling.
    assign rob_diff = sqn_cnt - bus.IN_comSqN;
    assign lq_diff  = ld_cnt - bus.IN_comLoadSqN;
    assign sq_diff  = st_cnt + SQN_W'(1) - bus.IN_comStoreSqN;
    assign rob_use  = {1'b0, rob_diff} + (SQN_W+1)'(n);
    assign lq_use   = {1'b0, lq_diff} + (SQN_W+1)'(nl);
    assign sq_use   = {1'b0, sq_diff} + (SQN_W+1)'(ns);
    assign fit      = (rob_use <= (SQN_W+1)'(ROB_SIZE)) &&
                      (lq_use <= (SQN_W+1)'(LQ_SIZE)) &&
                      (sq_use <= (SQN_W+1)'(SQ_SIZE));

    assign hold   = (|out_valid) && !bus.IN_ready;
    assign stall  = hold || ((|bus.IN_uopValid) && !fit) || bus.IN_branchTaken;
    assign accept = !rst && !bus.IN_branchTaken && !stall;

    // Counter and output registers: reset, then recovery, then allocate, else hold or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sqn_cnt   <= '0;
            ld_cnt    <= '0;
            st_cnt    <= '1;
            ord_bit   <= 1'b0;
            out_valid <= '0;
            out_sqn   <= '0;
            out_ld    <= '0;
            out_st    <= '0;
            out_ord   <= '0;
        end else if (bus.IN_branchTaken) begin
            sqn_cnt   <= bus.IN_branchSqN + SQN_W'(1);
            ld_cnt    <= bus.IN_branchLoadSqN;
            st_cnt    <= bus.IN_branchStoreSqN;
            ord_bit   <= 1'b0;
            out_valid <= '0;
        end else if (accept) begin
            sqn_cnt   <= sqn_cnt + SQN_W'(n);
            ld_cnt    <= ld_cnt + SQN_W'(nl);
            st_cnt    <= st_cnt + SQN_W'(ns);
            ord_bit   <= ord_out;
            out_valid <= bus.IN_uopValid;
            out_sqn   <= lane_sqn;
            out_ld    <= lane_ld;
            out_st    <= lane_st;
            out_ord   <= lane_ord & bus.IN_uopValid;
        end else if (!hold) begin
            out_valid <= '0;
        end
    end

    assign bus.OUT_stall        = stall;
    assign bus.OUT_uopValid     = out_valid;
    assign bus.OUT_uopSqN       = out_sqn;
    assign bus.OUT_uopLoadSqN   = out_ld;
    assign bus.OUT_uopStoreSqN  = out_st;
    assign bus.OUT_uopOrdering  = out_ord;
    assign bus.OUT_nextSqN      = sqn_cnt;
    assign bus.OUT_nextLoadSqN  = ld_cnt;
    assign bus.OUT_nextStoreSqN = st_cnt + SQN_W'(1);
endmodule

// File: tb/tb_rename_seq_alloc.sv
// Bench for rename_seq_alloc: directed vector table for the documented
// scenarios, then random traffic against a lane-by-lane behavioural model.
module tb_rename_seq_alloc;
    import rename_pkg::*;

    localparam int W   = 4;
    localparam int QW  = 7;
    localparam int MOD = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rename_seq_alloc_if #(.WIDTH(W), .SQN_W(QW)) bus();

    rename_seq_alloc #(.WIDTH(W), .SQN_W(QW), .ROB_SIZE(64), .LQ_SIZE(16), .SQ_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference state, kept as plain integers
    int       m_sqn, m_ld, m_st;
    bit       m_ord;
    bit [3:0] m_ov;
    int       m_osqn[W], m_old[W], m_ost[W];
    bit       m_oord[W];

    typedef struct {
        bit       rst;
        bit [3:0] valid;
        bit [15:0] fu;
        bit       ready;
        bit       br;
        bit [6:0] bsqn, bld, bst;
        bit [6:0] com, coml, coms;
        bit       exp_stall;
        bit [3:0] exp_valid;
        bit [6:0] exp_nsqn, exp_nld, exp_nst;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit r, bit [3:0] v, bit [15:0] f, bit rd, bit b,
                                bit [6:0] bs, bit [6:0] bl, bit [6:0] bt,
                                bit [6:0] c, bit [6:0] cl, bit [6:0] cs,
                                bit es, bit [3:0] ev, bit [6:0] en, bit [6:0] el, bit [6:0] et);
        vec_t x;
        x.rst = r; x.valid = v; x.fu = f; x.ready = rd; x.br = b;
        x.bsqn = bs; x.bld = bl; x.bst = bt; x.com = c; x.coml = cl; x.coms = cs;
        x.exp_stall = es; x.exp_valid = ev; x.exp_nsqn = en; x.exp_nld = el; x.exp_nst = et;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int md(int x);
        return ((x % MOD) + MOD) % MOD;
    endfunction

    function automatic bit m_stall();
        int n = 0, nl = 0, ns = 0;
        bit hold, fit;
        for (int i = 0; i < W; i++) begin
            if (bus.IN_uopValid[i]) begin
                n++;
                if (bus.IN_uopFu[4*i +: 4] == FU_LD) nl++;
                if (bus.IN_uopFu[4*i +: 4] == FU_ST) ns++;
            end
        end
        hold = (m_ov != 0) && !bus.IN_ready;
        fit  = (md(m_sqn - int'(bus.IN_comSqN)) + n <= 64) &&
               (md(m_ld - int'(bus.IN_comLoadSqN)) + nl <= 16) &&
               (md(m_st + 1 - int'(bus.IN_comStoreSqN)) + ns <= 16);
        return hold || (bus.IN_uopValid != 0 && !fit) || bus.IN_branchTaken;
    endfunction

    task automatic m_edge();
        bit       stl, hold, o;
        int       s, l, t;
        logic [3:0] f;
        stl  = m_stall();
        hold = (m_ov != 0) && !bus.IN_ready;
        if (rst) begin
            m_sqn = 0; m_ld = 0; m_st = MOD - 1; m_ord = 0; m_ov = 0;
            for (int i = 0; i < W; i++) begin
                m_osqn[i] = 0; m_old[i] = 0; m_ost[i] = 0; m_oord[i] = 0;
            end
        end else if (bus.IN_branchTaken) begin
            m_sqn = md(int'(bus.IN_branchSqN) + 1);
            m_ld  = int'(bus.IN_branchLoadSqN);
            m_st  = int'(bus.IN_branchStoreSqN);
            m_ord = 0;
            m_ov  = 0;
        end else if (hold) begin
            m_ov = m_ov;
        end else if (!stl) begin
            s = m_sqn; l = m_ld; t = m_st; o = m_ord;
            for (int i = 0; i < W; i++) begin
                if (bus.IN_uopValid[i]) begin
                    f = bus.IN_uopFu[4*i +: 4];
                    m_osqn[i] = s; s = md(s + 1);
                    m_old[i]  = l;
                    if (f == FU_LD) l = md(l + 1);
                    if (f == FU_ST) t = md(t + 1);
                    m_ost[i]  = t;
                    m_oord[i] = o;
                    if (f == FU_INT) o = !o;
                    else if (f == FU_MUL || f == FU_DIV) o = 1;
                    else if (f == FU_FPU || f == FU_CSR || f == FU_BR) o = 0;
                end
            end
            m_sqn = s; m_ld = l; m_st = t; m_ord = o;
            m_ov = bus.IN_uopValid;
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"}, bus.OUT_uopValid, m_ov);
        chk({tag, " nextSqN"}, bus.OUT_nextSqN, m_sqn);
        chk({tag, " nextLoadSqN"}, bus.OUT_nextLoadSqN, m_ld);
        chk({tag, " nextStoreSqN"}, bus.OUT_nextStoreSqN, md(m_st + 1));
        for (int i = 0; i < W; i++) begin
            if (m_ov[i]) begin
                chk($sformatf("%s lane%0d sqn", tag, i), bus.OUT_uopSqN[QW*i +: QW], m_osqn[i]);
                chk($sformatf("%s lane%0d ld", tag, i), bus.OUT_uopLoadSqN[QW*i +: QW], m_old[i]);
                chk($sformatf("%s lane%0d st", tag, i), bus.OUT_uopStoreSqN[QW*i +: QW], m_ost[i]);
                chk($sformatf("%s lane%0d ord", tag, i), bus.OUT_uopOrdering[i], m_oord[i]);
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, " stall(model)"}, bus.OUT_stall, m_stall());
        @(posedge clk);
        m_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit r, input bit [3:0] v, input bit [15:0] f, input bit rd,
                         input bit b, input bit [6:0] bs, input bit [6:0] bl, input bit [6:0] bt,
                         input bit [6:0] c, input bit [6:0] cl, input bit [6:0] cs);
        rst = r;
        bus.IN_uopValid = v; bus.IN_uopFu = f; bus.IN_ready = rd; bus.IN_branchTaken = b;
        bus.IN_branchSqN = bs; bus.IN_branchLoadSqN = bl; bus.IN_branchStoreSqN = bt;
        bus.IN_comSqN = c; bus.IN_comLoadSqN = cl; bus.IN_comStoreSqN = cs;
    endtask

    initial begin
        m_sqn = 0; m_ld = 0; m_st = MOD - 1; m_ord = 0; m_ov = 0;
        for (int i = 0; i < W; i++) begin
            m_osqn[i] = 0; m_old[i] = 0; m_ost[i] = 0; m_oord[i] = 0;
        end

        //          rst v     fu        rdy br bsqn   bld    bst    com    coml   coms   es ev     nsqn   nld    nst
        tbl[0]  = mk(0, 4'hF, 16'h0210, 1, 0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 0, 4'hF, 7'h04, 7'h01, 7'h01);
        tbl[1]  = mk(0, 4'h0, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 0, 4'h0, 7'h04, 7'h01, 7'h01);
        tbl[2]  = mk(0, 4'h0, 16'h0000, 1, 1, 7'h3F, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 1, 4'h0, 7'h40, 7'h01, 7'h01);
        tbl[3]  = mk(0, 4'h1, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1, 4'h0, 7'h40, 7'h01, 7'h01);
        tbl[4]  = mk(0, 4'h1, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1, 4'h0, 7'h40, 7'h01, 7'h01);
        tbl[5]  = mk(0, 4'h1, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 0, 4'h1, 7'h41, 7'h01, 7'h01);
        tbl[6]  = mk(0, 4'hF, 16'h0210, 0, 0, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 1, 4'h1, 7'h41, 7'h01, 7'h01);
        tbl[7]  = mk(0, 4'hF, 16'h0210, 0, 0, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 1, 4'h1, 7'h41, 7'h01, 7'h01);
        tbl[8]  = mk(0, 4'hF, 16'h0210, 0, 0, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 1, 4'h1, 7'h41, 7'h01, 7'h01);
        tbl[9]  = mk(0, 4'hF, 16'h0210, 1, 0, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 0, 4'hF, 7'h45, 7'h02, 7'h02);
        tbl[10] = mk(0, 4'h0, 16'h0000, 1, 1, 7'h7D, 7'h02, 7'h01, 7'h20, 7'h00, 7'h00, 1, 4'h0, 7'h7E, 7'h02, 7'h02);
        tbl[11] = mk(0, 4'hF, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h7C, 7'h00, 7'h00, 0, 4'hF, 7'h02, 7'h02, 7'h02);
        tbl[12] = mk(0, 4'hF, 16'h0000, 0, 0, 7'h00, 7'h00, 7'h00, 7'h7C, 7'h00, 7'h00, 1, 4'hF, 7'h02, 7'h02, 7'h02);
        tbl[13] = mk(0, 4'hF, 16'h0000, 0, 1, 7'h10, 7'h05, 7'h03, 7'h7C, 7'h00, 7'h00, 1, 4'h0, 7'h11, 7'h05, 7'h04);
        tbl[14] = mk(0, 4'hF, 16'h0000, 1, 0, 7'h00, 7'h00, 7'h00, 7'h7C, 7'h00, 7'h00, 0, 4'hF, 7'h15, 7'h05, 7'h04);
        tbl[15] = mk(0, 4'hF, 16'h0000, 0, 0, 7'h00, 7'h00, 7'h00, 7'h7C, 7'h00, 7'h00, 1, 4'hF, 7'h15, 7'h05, 7'h04);
        tbl[16] = mk(1, 4'hF, 16'h0000, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1, 4'h0, 7'h00, 7'h00, 7'h00);

        // reset
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        m_edge();
        #1;
        step("reset");
        chk("reset stall", bus.OUT_stall, 1'b0);
        chk("reset valid", bus.OUT_uopValid, 4'h0);
        chk("reset sqn", bus.OUT_uopSqN, 28'h0);
        chk("reset nextStore", bus.OUT_nextStoreSqN, 7'h00);

        // directed table
        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].rst, tbl[k].valid, tbl[k].fu, tbl[k].ready, tbl[k].br,
                  tbl[k].bsqn, tbl[k].bld, tbl[k].bst, tbl[k].com, tbl[k].coml, tbl[k].coms);
            @(negedge clk);
            chk($sformatf("vec%0d stall", k), bus.OUT_stall, tbl[k].exp_stall);
            chk($sformatf("vec%0d stall(model)", k), bus.OUT_stall, m_stall());
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("vec%0d valid", k), bus.OUT_uopValid, tbl[k].exp_valid);
            chk($sformatf("vec%0d nextSqN", k), bus.OUT_nextSqN, tbl[k].exp_nsqn);
            chk($sformatf("vec%0d nextLoadSqN", k), bus.OUT_nextLoadSqN, tbl[k].exp_nld);
            chk($sformatf("vec%0d nextStoreSqN", k), bus.OUT_nextStoreSqN, tbl[k].exp_nst);
            check_model($sformatf("vec%0d", k));
            if (k == 0) begin
                chk("first sqn", bus.OUT_uopSqN, {7'h03, 7'h02, 7'h01, 7'h00});
                chk("first ld", bus.OUT_uopLoadSqN, {7'h01, 7'h01, 7'h00, 7'h00});
                chk("first st", bus.OUT_uopStoreSqN, {7'h00, 7'h00, 7'h7F, 7'h7F});
                chk("first ord", bus.OUT_uopOrdering, 4'b1110);
            end
            if (k == 5) chk("robfull sqn", bus.OUT_uopSqN[6:0], 7'h40);
            if (k == 8) chk("held sqn", bus.OUT_uopSqN[6:0], 7'h40);
            if (k == 9) begin
                chk("release sqn", bus.OUT_uopSqN, {7'h44, 7'h43, 7'h42, 7'h41});
                chk("release ld", bus.OUT_uopLoadSqN, {7'h02, 7'h02, 7'h01, 7'h01});
                chk("release st", bus.OUT_uopStoreSqN, {7'h01, 7'h01, 7'h00, 7'h00});
                chk("release ord", bus.OUT_uopOrdering, 4'b0001);
            end
            if (k == 11) chk("wrap sqn", bus.OUT_uopSqN, {7'h01, 7'h00, 7'h7F, 7'h7E});
            if (k == 16) begin
                chk("rst drop sqn", bus.OUT_uopSqN, 28'h0);
                chk("rst drop ld", bus.OUT_uopLoadSqN, 28'h0);
                chk("rst drop st", bus.OUT_uopStoreSqN, 28'h0);
                chk("rst drop ord", bus.OUT_uopOrdering, 4'h0);
            end
        end

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bit [15:0] f;
            for (int i = 0; i < W; i++) f[4*i +: 4] = 4'($urandom_range(0, 8));
            drive($urandom_range(0, 99) < 2,
                  4'($urandom_range(0, 15)), f,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 5,
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                  7'(md(m_sqn - int'($urandom_range(0, 70)))),
                  7'(md(m_ld - int'($urandom_range(0, 18)))),
                  7'(md(m_st + 1 - int'($urandom_range(0, 18)))));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
